// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the table-driven sequence generator.
// Holds the FSM state encoding, the table reset value and select-width math.
package seq_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Every table bit clears to this value.
    localparam logic TABLE_RST_BIT = 1'b0;

    // Width of a select bus addressing n entries; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_gen_param_if.sv
// Control, table-write and status bundle of the sequence generator.
// Widths follow the WIDTH/DEPTH/MODES parameters of the attached generator.
interface seq_gen_param_if
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int MODES = 2
) ();
    localparam int IDX_W  = sel_width(DEPTH);
    localparam int MODE_W = sel_width(MODES);

    logic              start;
    logic              stop;
    logic              en;
    logic              loop;
    logic [MODE_W-1:0] mode;
    logic              wr_en;
    logic [MODE_W-1:0] wr_mode;
    logic [IDX_W-1:0]  wr_idx;
    logic [WIDTH-1:0]  wr_data;
    logic [WIDTH-1:0]  seq;
    logic [IDX_W-1:0]  idx;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, en, loop, mode, wr_en, wr_mode, wr_idx, wr_data,
        input  seq, idx, busy, done
    );

    modport slave (
        input  start, stop, en, loop, mode, wr_en, wr_mode, wr_idx, wr_data,
        output seq, idx, busy, done
    );

endinterface

// File: rtl/seq_pattern_table.sv
// MODES x DEPTH x WIDTH pattern register file: synchronous range-checked write,
// combinational read (a write shows on rd_data one edge later); never stalls.
module seq_pattern_table
    import seq_gen_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 4,
    parameter int MODES  = 2,
    parameter int IDX_W  = sel_width(DEPTH),
    parameter int MODE_W = sel_width(MODES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [MODE_W-1:0] wr_mode,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [MODE_W-1:0] rd_mode,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] mem [MODES][DEPTH];
    logic             wr_ok;

    // Addresses beyond the populated table are dropped, not aliased.
    assign wr_ok = wr_en && (int'(wr_mode) < MODES) && (int'(wr_idx) < DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int m = 0; m < MODES; m++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    mem[m][d] <= {WIDTH{TABLE_RST_BIT}};
                end
            end
        end else if (wr_ok) begin
            mem[wr_mode][wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_mode][rd_idx];

endmodule

// File: rtl/seq_gen_param.sv
// Table-driven sequence generator: one-shot or looping walk over DEPTH words.
// Zero-cycle state-to-output latency; en gates stepping, stop aborts without done.
module seq_gen_param
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int MODES = 2
) (
    input  logic            clk,
    input  logic            rst,
    seq_gen_param_if.slave  bus
);
    localparam int IDX_W  = sel_width(DEPTH);
    localparam int MODE_W = sel_width(MODES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx_q, idx_nx;
    logic [MODE_W-1:0] mode_q, mode_nx, mode_in;
    logic [WIDTH-1:0]  rd_data;
    logic              done_c;
    logic              running;

    // Unpopulated mode selects fall back to pattern set 0.
    assign mode_in = (int'(bus.mode) < MODES) ? bus.mode : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx_q  <= '0;
            mode_q <= '0;
        end else begin
            state  <= state_nx;
            idx_q  <= idx_nx;
            mode_q <= mode_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx_q;
        mode_nx  = mode_q;
        done_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_nx = ST_RUN;
                    idx_nx   = '0;
                    mode_nx  = mode_in;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_nx = ST_IDLE;
                    idx_nx   = '0;
                end else if (bus.start) begin
                    idx_nx  = '0;
                    mode_nx = mode_in;
                end else if (bus.en) begin
                    if (idx_q != LAST) begin
                        idx_nx = idx_q + 1'b1;
                    end else begin
                        // Last step: completion pulse, then wrap or fall idle.
                        done_c = 1'b1;
                        idx_nx = '0;
                        if (bus.loop) begin
                            mode_nx = mode_in;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    seq_pattern_table #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .MODES  (MODES),
        .IDX_W  (IDX_W),
        .MODE_W (MODE_W)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.wr_en),
        .wr_mode (bus.wr_mode),
        .wr_idx  (bus.wr_idx),
        .wr_data (bus.wr_data),
        .rd_mode (mode_q),
        .rd_idx  (idx_q),
        .rd_data (rd_data)
    );

    assign running  = (state == ST_RUN);
    assign bus.busy = running;
    assign bus.idx  = running ? idx_q : '0;
    assign bus.seq  = running ? rd_data : '0;
    assign bus.done = done_c && !rst;

endmodule

// File: doc/seq_gen_param.md
# seq_gen_param

Parametrised, table-driven sequence generator. It steps through a programmable list of `DEPTH` words of `WIDTH` bits, chosen from one of `MODES` pattern sets. Compared with the fixed 4-step, 2-mode generator, it adds runtime-loadable patterns, step gating, one-shot or loop operation, abort, and status outputs. It sits between control logic and any datapath that needs a repeating or single-pass code sequence.

## Interface
- `WIDTH`, 4: bits per output word (≥1).
- `DEPTH`, 4: steps per sequence (≥2).
- `MODES`, 2: number of pattern sets (≥1).
- `IDX_W`, `$clog2(DEPTH)`: derived step-index width; not overridden.
- `MODE_W`, `max(1,$clog2(MODES))`: derived mode-select width; not overridden.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a sequence at step 0.
- `stop` in 1: abort to idle, no `done`.
- `en` in 1: advance one step per cycle while high.
- `loop` in 1: 1 = wrap forever, 0 = one-shot; sampled at the last step.
- `mode` in `MODE_W`: pattern set; latched at start and at each wrap.
- `wr_en` in 1: table write strobe.
- `wr_mode` in `MODE_W`: table write, mode address.
- `wr_idx` in `IDX_W`: table write, step address.
- `wr_data` in `WIDTH`: table write data.
- `seq` out `WIDTH`: current word; 0 when idle.
- `idx` out `IDX_W`: current step; 0 when idle.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse at sequence completion or wrap.

## Operation
- **Reset values:** state=IDLE, `idx`=0, `mode_q`=0, `seq`=0, `busy`=0, `done`=0. All table entries clear to 0.
- **State machine:** two states, IDLE and RUN.
  - IDLE → RUN on `start`: `idx`←0, `mode_q`←`mode`.
  - RUN → IDLE on `stop`, or on `en` at step `DEPTH-1` with `loop`=0.
- **Priority in RUN:** `stop` > `start` > `en`.
  - `start` in RUN restarts: `idx`←0, `mode_q` re-latched, no `done`.
  - `stop` and `start` together in IDLE: stay IDLE.
- **Stepping, RUN with `en`=1:**
  - At `idx`<`DEPTH-1`: `idx`←`idx`+1.
  - At `idx`=`DEPTH-1` with `loop`=1: `idx`←0, `mode_q`←`mode`, `done`=1 for that cycle.
  - At `idx`=`DEPTH-1` with `loop`=0: go to IDLE, `done`=1 for that cycle.
- **Hold:** with `en`=0, `idx` and `seq` hold.
- **Output:** `seq` = `table[mode_q][idx]` in RUN, 0 in IDLE. It is combinational from registers.
- **Table writes:**
  - Accepted in any state. The entry updates on the edge where `wr_en`=1.
  - If the entry is currently selected, `seq` shows the new value from the next cycle.
  - Writes with `wr_mode`≥`MODES` or `wr_idx`≥`DEPTH` are ignored.
- **Mode range:** a `mode`≥`MODES` latches as 0.
- **Reset mid-run:** returns to IDLE with table cleared. No `done` is produced.

## Timing
- `start` at edge t: `busy`=1, `idx`=0, and `seq`=`table[mode][0]` are visible after t.
- Each `en` edge advances one step. Latency is zero cycles from state to `seq`.
- `done` is asserted combinationally in the cycle where `en`=1 at the last step. It is high for exactly one cycle per completion.
- A full one-shot pass with `en` held high takes `DEPTH` cycles. `busy` drops after the `DEPTH`th edge.
- The table write-to-`seq` latency is one edge.

## Structure
- Package `seq_gen_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_RUN`);
  - the reset table value constant (all zeros);
  - a helper function computing `MODE_W`/`IDX_W`.
- Sub-module `seq_pattern_table` is the `MODES`×`DEPTH`×`WIDTH` register file. It has:
  - a synchronous write port with address range check;
  - a combinational read port;
  - clear on `rst`.
- The top level contains the FSM, the step counter, and the mode latch.

## Test plan
- **Reset/idle:** `rst`=1 for 2 cycles → `seq`=0, `idx`=0, `busy`=0, `done`=0. Table read-back after `start` gives 0.
- **Loop, default parameters:**
  - Stimulus: write mode0 = {8,9,A,C} and mode1 = {3,6,5,A}; `start` with `mode`=0, `loop`=1, `en`=1.
  - Response: `seq` = 8,9,A,C,8…; `done` pulses every 4th cycle at `idx`=3.
  - Changing `mode` to 1 mid-pass takes effect only after the wrap (next pass = 3,6,5,A).
- **One-shot:** `loop`=0, `en`=1, mode1 → `seq` = 3,6,5,A; `done`=1 with `seq`=A; then `busy`=0 and `seq`=0.
- **Gating/abort:** `en` low at `idx`=2 for 3 cycles → `seq` holds 5. Then `stop`+`en` together → IDLE with no `done`.
- **Restart/write collision:**
  - `start` at `idx`=2 → `idx`=0 with no `done`.
  - Writing `F` to the selected entry → `seq`=F the next cycle.
  - A write with `wr_idx`=5 when `DEPTH`=5 is ignored.
- **Parameter sweep:** `WIDTH`=8, `DEPTH`=5, `MODES`=3, loop pass → wrap from `idx` 4 to 0. A `mode`=3 input behaves as mode 0.
